// File: rtl/fetch_seq_if.sv
// ============================================================================
// Module   : fetch_seq_if
// Purpose  : Instruction-memory request/acknowledge bus between the fetch
//            sequencer (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MemReq;
    logic [DATA_WIDTH-1:0] MemAddr;
    logic                  MemAck;
    logic [DATA_WIDTH-1:0] MemData;

    modport master (
        output MemReq,
        output MemAddr,
        input  MemAck,
        input  MemData
    );

    modport slave (
        input  MemReq,
        input  MemAddr,
        output MemAck,
        output MemData
    );
endinterface

`default_nettype wire

// File: rtl/fetch_seq.sv
// ============================================================================
// Module   : fetch_seq
// Purpose  : RV32I fetch sequencer: owns PCf, drives the instruction memory
//            handshake, feeds the F/D register through a one-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_seq #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  PCsrcE,
    input  wire logic [DATA_WIDTH-1:0] PCTargetE,
    input  wire logic                  StallD,
    fetch_seq_if.master                mem,
    output logic      [DATA_WIDTH-1:0] PCf,
    output logic      [DATA_WIDTH-1:0] InstrD,
    output logic      [DATA_WIDTH-1:0] PCd,
    output logic      [DATA_WIDTH-1:0] PCPlus4D,
    output logic                       ValidD
);

    localparam logic [DATA_WIDTH-1:0] c_PC_STEP = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pcf;
    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pc4_d;
    logic                  r_valid_d;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_instr;
    logic [DATA_WIDTH-1:0] r_skid_pc;
    logic [DATA_WIDTH-1:0] r_drain_addr;

    logic [DATA_WIDTH-1:0] w_pcf_plus4;
    logic [DATA_WIDTH-1:0] w_skid_pc_plus4;

    assign w_pcf_plus4     = r_pcf + c_PC_STEP;
    assign w_skid_pc_plus4 = r_skid_pc + c_PC_STEP;

    // A redirected-but-unacknowledged request keeps its address alive in DRAIN
    assign mem.MemReq  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign mem.MemAddr = (r_state == ST_DRAIN) ? r_drain_addr : r_pcf;

    assign PCf      = r_pcf;
    assign InstrD   = r_instr_d;
    assign PCd      = r_pc_d;
    assign PCPlus4D = r_pc4_d;
    assign ValidD   = r_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pcf        <= RESET_PC;
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_pc4_d      <= '0;
            r_valid_d    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_drain_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end

                ST_REQ: begin
                    if (PCsrcE) begin
                        r_pcf        <= PCTargetE;
                        r_valid_d    <= 1'b0;
                        r_skid_valid <= 1'b0;
                        if (!mem.MemAck) begin
                            r_drain_addr <= r_pcf;
                            r_state      <= ST_DRAIN;
                        end
                    end else if (mem.MemAck) begin
                        r_pcf <= w_pcf_plus4;
                        if (!StallD) begin
                            r_instr_d <= mem.MemData;
                            r_pc_d    <= r_pcf;
                            r_pc4_d   <= w_pcf_plus4;
                            r_valid_d <= 1'b1;
                        end else begin
                            r_skid_instr <= mem.MemData;
                            r_skid_pc    <= r_pcf;
                            r_skid_valid <= 1'b1;
                            r_state      <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (PCsrcE) begin
                        r_pcf        <= PCTargetE;
                        r_valid_d    <= 1'b0;
                        r_skid_valid <= 1'b0;
                        r_state      <= ST_REQ;
                    end else if (!StallD) begin
                        r_instr_d    <= r_skid_instr;
                        r_pc_d       <= r_skid_pc;
                        r_pc4_d      <= w_skid_pc_plus4;
                        r_valid_d    <= r_skid_valid;
                        r_skid_valid <= 1'b0;
                        r_state      <= ST_REQ;
                    end
                end

                ST_DRAIN: begin
                    if (PCsrcE) begin
                        r_pcf        <= PCTargetE;
                        r_valid_d    <= 1'b0;
                        r_skid_valid <= 1'b0;
                    end else if (mem.MemAck) begin
                        r_state <= ST_REQ;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fetch_seq.md
# fetch_seq

Fetch sequencer for the pipelined RV32I core. It owns the fetch-stage PC and drives a variable-latency instruction memory through a request/acknowledge handshake. It loads the fetch/decode pipeline register and holds it under decode stalls, using a one-entry skid buffer. It resolves execute-stage redirects (taken branches and jumps) against any request still outstanding, including flushing the decode stage.

## Interface
- DATA_WIDTH, 32, width of PC, instruction and memory data
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- PCsrcE  in  1  redirect request from execute (taken branch/jump)
- PCTargetE  in  DATA_WIDTH  redirect target, valid when PCsrcE=1
- StallD  in  1  decode stall from the hazard unit; the D register must hold
- MemReq  out  1  instruction memory request
- MemAddr  out  DATA_WIDTH  request address, stable while MemReq=1
- MemAck  in  1  memory returns MemData this cycle; only meaningful when MemReq=1
- MemData  in  DATA_WIDTH  instruction word
- PCf  out  DATA_WIDTH  current fetch PC
- InstrD  out  DATA_WIDTH  decode-stage instruction
- PCd  out  DATA_WIDTH  decode-stage PC
- PCPlus4D  out  DATA_WIDTH  decode-stage PC+4
- ValidD  out  1  decode-stage contents valid; 0 = bubble

## Operation
- States: IDLE, REQ, HOLD, DRAIN.
- Reset values:
  - state=IDLE, PCf=RESET_PC.
  - InstrD=0, PCd=0, PCPlus4D=0, ValidD=0.
  - Skid buffer empty. Drain address register = 0.
- Reset applied in any state, mid-request included, returns all of the above the next edge. A memory response in flight is not tracked across reset.
- MemReq=1 only in REQ and DRAIN.
  - In REQ, MemAddr=PCf.
  - In DRAIN, MemAddr = the latched drain address.
- IDLE: always goes to REQ on the next edge.
- REQ, edge with MemAck=1, PCsrcE=0, StallD=0:
  - Load D: InstrD=MemData, PCd=PCf, PCPlus4D=PCf+4, ValidD=1.
  - PCf<=PCf+4. Stay in REQ.
- REQ, edge with MemAck=1, PCsrcE=0, StallD=1:
  - D holds.
  - Skid captures {MemData, PCf}. PCf<=PCf+4. Go to HOLD.
- REQ, edge with MemAck=0, PCsrcE=0: no change (StallD is irrelevant).
- HOLD: MemReq=0.
  - On an edge with StallD=0: load D from the skid, ValidD=1, empty the skid, go to REQ.
  - While StallD=1, hold everything.
- Redirect (PCsrcE=1) takes priority over StallD and MemAck in every state except IDLE:
  - PCf<=PCTargetE. ValidD<=0; other D fields are don't-care. Skid emptied.
  - From REQ with MemAck=0: latch the drain address = old PCf, go to DRAIN. The outstanding request is kept alive.
  - From REQ with MemAck=1: the returned data is discarded; stay in REQ, fetching the target next.
  - From HOLD: go to REQ.
  - From DRAIN: stay in DRAIN.
- DRAIN: MemReq=1 at the old address.
  - On MemAck=1, discard MemData and go to REQ, fetching PCf.
  - ValidD stays 0 throughout.
- Arithmetic: PC+4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC+4 = 0). PCTargetE is used unmodified; alignment is not checked.
- Memory contract: at most one request outstanding. MemAddr must not change while MemReq=1 and MemAck=0, and the block guarantees this.

## Timing
- All state and outputs are registered on the rising edge of clk. MemReq and MemAddr are decoded from the registered state and PCf only.
- MemAck may be asserted in the first cycle MemReq is high, giving zero-wait memory.
- Zero-wait, unstalled: one instruction per cycle. The first valid ValidD appears 2 edges after rst deasserts (IDLE, then REQ).
- N-wait memory: one instruction every N+1 cycles.
- Redirect-to-fetch latency:
  - No request outstanding: the target appears on MemAddr the cycle after the PCsrcE edge.
  - Request outstanding: the target appears the cycle after the drain ack.
- A stalled D register with an ack produces exactly one skid fill. There are no fetch requests in HOLD.

## Test plan
- Reset and stream, MemAck tied to 1, RESET_PC=0 → MemAddr 0,4,8,… on consecutive cycles. ValidD=1 from the 2nd edge after reset. PCd/InstrD pairs match the memory model.
- Memory with 2 wait states → MemAddr held stable for 3 cycles per fetch. One valid D entry per 3 cycles. No address change before the ack.
- StallD=1 for 4 cycles with ack on the first stalled cycle:
  - D holds its old instruction. Enter HOLD, MemReq=0.
  - The skid word (address 0x10) appears in D the edge after StallD falls, and PCf=0x14.
- PCsrcE=1 with target 0x200 while the request to 0x40 waits 3 cycles:
  - MemAddr stays 0x40 until its ack, and that data is discarded (ValidD=0).
  - MemAddr is 0x200 the next cycle, and PCd=0x200 is loaded with ValidD=1.
- PCsrcE=1 and StallD=1 on the same edge with HOLD full → ValidD=0, skid emptied, PCf=target, state REQ.
- Wrap: RESET_PC=32'hFFFF_FFFC, zero-wait → PCPlus4D=0, next MemAddr=0. Reset asserted mid-DRAIN → IDLE, PCf=RESET_PC, ValidD=0 on the next edge.
